// File: rtl/adc_frame_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// adc_arb_pkg
//   Shared types for the ADC frame arbiter: default ADC word width, the
//   arbiter FSM state encoding and the captured-frame record.
// ----------------------------------------------------------------------------
package adc_arb_pkg;

    localparam int ADC_DATA_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // One completed SPI frame (word pair).
    typedef struct packed {
        logic [ADC_DATA_W-1:0] data0;
        logic [ADC_DATA_W-1:0] data1;
    } frame_t;

endpackage

// File: rtl/adc_frame_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: scans the request vector starting at the
//   pointer and returns the first requester as a one-hot grant plus its index.
// Ports
//   req    in   NUM_REQ  request vector
//   ptr    in   PTR_W    index with highest priority this round
//   gnt    out  NUM_REQ  one-hot pick (0 when no request)
//   idx    out  PTR_W    index of the picked requester
//   valid  out  1        at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   idx,
    output logic               valid
);

    int pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = (int'(ptr) + i) % NUM_REQ;
            if (!valid && req[pos]) begin
                valid    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/adc_frame_arbiter.sv
// ----------------------------------------------------------------------------
// adc_frame_arbiter
//   Captures each completed ADC SPI frame, tracks per-consumer freshness and a
//   link timeout, and shares the frame read port between NUM_REQ consumers
//   with round-robin, single-cycle grants.
//   Optional feature: define ADC_SMOOTH_EN to pass each captured word through
//   a first-order IIR (coefficient 2^-SMOOTH_SHIFT) before it is stored.
//   The frame record width comes from adc_arb_pkg::ADC_DATA_W; DATA_W must
//   match it.
// Ports
//   i_clock          in   1        system clock
//   i_reset          in   1        synchronous active-low reset
//   i_data0/1        in   DATA_W   words from the SPI front end
//   i_data_received  in   1        frame-complete flag, rising edge = new frame
//   i_req            in   NUM_REQ  per-consumer request, held until granted
//   o_gnt            out  NUM_REQ  one-hot single-cycle grant
//   o_data0/1        out  DATA_W   frame words, zero unless a grant is active
//   o_fresh          out  NUM_REQ  frame captured since consumer's last grant
//   o_stale          out  1        no frame for TIMEOUT_CYCLES
//   o_frame_count    out  8        wrapping captured-frame counter
// ----------------------------------------------------------------------------
module adc_frame_arbiter
    import adc_arb_pkg::*;
#(
    parameter int DATA_W         = ADC_DATA_W,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 133000,
    parameter int SMOOTH_SHIFT   = 3
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [DATA_W-1:0]  i_data0,
    input  logic [DATA_W-1:0]  i_data1,
    input  logic               i_data_received,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [DATA_W-1:0]  o_data0,
    output logic [DATA_W-1:0]  o_data1,
    output logic [NUM_REQ-1:0] o_fresh,
    output logic               o_stale,
    output logic [7:0]         o_frame_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    arb_state_t         state;
    frame_t             frame;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic               rcv_prev;
    logic               cap;
    logic [NUM_REQ-1:0] pick;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [NUM_REQ-1:0] fresh_clr;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req   (i_req),
        .ptr   (ptr),
        .gnt   (pick),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Capture on the rising edge of the frame-complete level.
    assign cap      = i_data_received & ~rcv_prev;
    assign ptr_next = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

    // Only a grant issued from IDLE clears freshness; a capture on the same
    // edge re-sets the bit because the granted data is the older frame.
    assign fresh_clr = (state == IDLE) ? pick : '0;

    always_comb begin
        cnt_next = cnt;
        if (cap)
            cnt_next = '0;
        else if (cnt != CNT_MAX)
            cnt_next = cnt + 1'b1;
    end

`ifdef ADC_SMOOTH_EN
    logic primed;

    // y + ((x - y) >>> SMOOTH_SHIFT) with a one-bit-wider signed difference,
    // truncated back to the word width.
    function automatic logic [DATA_W-1:0] smooth(input logic [DATA_W-1:0] y,
                                                 input logic [DATA_W-1:0] x);
        logic signed [DATA_W:0] diff;
        diff = $signed({1'b0, x}) - $signed({1'b0, y});
        diff = diff >>> SMOOTH_SHIFT;
        return y + diff[DATA_W-1:0];
    endfunction
`endif

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state         <= IDLE;
            frame         <= '0;
            ptr           <= '0;
            rcv_prev      <= 1'b0;
            cnt           <= '0;
            o_gnt         <= '0;
            o_data0       <= '0;
            o_data1       <= '0;
            o_fresh       <= '0;
            o_stale       <= 1'b0;
            o_frame_count <= '0;
`ifdef ADC_SMOOTH_EN
            primed        <= 1'b0;
`endif
        end else begin
            rcv_prev <= i_data_received;
            cnt      <= cnt_next;
            o_stale  <= (cnt_next == CNT_MAX);
            o_fresh  <= (o_fresh & ~fresh_clr) | {NUM_REQ{cap}};

            if (cap) begin
                o_frame_count <= o_frame_count + 8'd1;
`ifdef ADC_SMOOTH_EN
                primed <= 1'b1;
                if (!primed) begin
                    frame <= '{data0: i_data0, data1: i_data1};
                end else begin
                    frame.data0 <= smooth(frame.data0, i_data0);
                    frame.data1 <= smooth(frame.data1, i_data1);
                end
`else
                frame <= '{data0: i_data0, data1: i_data1};
`endif
            end

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state   <= GRANT;
                        o_gnt   <= pick;
                        o_data0 <= frame.data0;
                        o_data1 <= frame.data1;
                        ptr     <= ptr_next;
                    end
                end
                GRANT: begin
                    state   <= IDLE;
                    o_gnt   <= '0;
                    o_data0 <= '0;
                    o_data1 <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_arbiter.sv
`timescale 1ns/1ps
module tb_adc_frame_arbiter;

    localparam int DW = 16;
    localparam int NR = 2;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] d0, d1;
    logic          rcv;
    logic [NR-1:0] req;
    logic [NR-1:0] o_gnt;
    logic [DW-1:0] o_data0, o_data1;
    logic [NR-1:0] o_fresh;
    logic          o_stale;
    logic [7:0]    o_frame_count;

    always #5 clk = ~clk;

    adc_frame_arbiter #(
        .DATA_W         (DW),
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO),
        .SMOOTH_SHIFT   (3)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_data0         (d0),
        .i_data1         (d1),
        .i_data_received (rcv),
        .i_req           (req),
        .o_gnt           (o_gnt),
        .o_data0         (o_data0),
        .o_data1         (o_data1),
        .o_fresh         (o_fresh),
        .o_stale         (o_stale),
        .o_frame_count   (o_frame_count)
    );

    typedef struct {
        logic [NR-1:0] gnt;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    // Scoreboard: every grant pops one expected record; idle cycles must show
    // zero data on the read port.
    always @(negedge clk) begin
        if (mon_en) begin
            tests++;
            if (o_gnt !== '0) begin
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_grant: got gnt=%b data=%h/%h, required no grant",
                             o_gnt, o_data0, o_data1);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (o_gnt !== mon_e.gnt || o_data0 !== mon_e.d0 || o_data1 !== mon_e.d1) begin
                        fails++;
                        $display("FAIL grant_data: got gnt=%b data=%h/%h, required gnt=%b data=%h/%h",
                                 o_gnt, o_data0, o_data1, mon_e.gnt, mon_e.d0, mon_e.d1);
                    end
                end
            end else if (o_data0 !== '0 || o_data1 !== '0) begin
                fails++;
                $display("FAIL idle_leak: got data=%h/%h, required 0000/0000", o_data0, o_data1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [NR-1:0] g, input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        e.gnt = g; e.d0 = a; e.d1 = b;
        exp_q.push_back(e);
    endtask

    // Pulse the frame flag; returns one edge after the capture edge.
    task automatic capture(input logic [DW-1:0] a, input logic [DW-1:0] b);
        d0 = a; d1 = b; rcv = 1'b1;
        cyc(1);
        rcv = 1'b0;
        cyc(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
    endtask

    task automatic grant0();
        req = 2'b01;
        cyc(1);
        tests++;
        if (o_gnt !== 2'b01) begin
            fails++;
            $display("FAIL grant0_gnt: got %b, required 01", o_gnt);
        end
        req = 2'b00;
        cyc(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 2'b11; rcv = 1'b0; d0 = 16'h1234; d1 = 16'h5678;
        cyc(3);
        tests++;
        if (o_gnt !== 2'b00 || o_data0 !== 16'h0 || o_data1 !== 16'h0) begin
            fails++;
            $display("FAIL reset_port: got gnt=%b data=%h/%h, required 00 0000/0000", o_gnt, o_data0, o_data1);
        end
        tests++;
        if (o_fresh !== 2'b00 || o_stale !== 1'b0 || o_frame_count !== 8'd0) begin
            fails++;
            $display("FAIL reset_status: got fresh=%b stale=%b count=%0d, required 00 0 0",
                     o_fresh, o_stale, o_frame_count);
        end
        req = 2'b00; rst_n = 1'b1; mon_en = 1'b1;
        cyc(1);
    endtask

    task automatic test_capture_grant();
        capture(16'h00C8, 16'hFEAC);
        tests++;
        if (o_frame_count !== 8'd1 || o_fresh !== 2'b11) begin
            fails++;
            $display("FAIL capture: got count=%0d fresh=%b, required 1 11", o_frame_count, o_fresh);
        end
        push(2'b01, 16'h00C8, 16'hFEAC);
        grant0();
        tests++;
        if (o_fresh !== 2'b10) begin
            fails++;
            $display("FAIL fresh_clear: got %b, required 10", o_fresh);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] seq [5];
        seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        do_reset();
        push(2'b01, 16'h0, 16'h0);
        push(2'b10, 16'h0, 16'h0);
        push(2'b01, 16'h0, 16'h0);
        req = 2'b11;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            tests++;
            if (o_gnt !== seq[k]) begin
                fails++;
                $display("FAIL rr_seq[%0d]: got %b, required %b", k, o_gnt, seq[k]);
            end
        end
        req = 2'b00;
        cyc(1);
        tests++;
        if (o_gnt !== 2'b00) begin
            fails++;
            $display("FAIL rr_stop: got %b, required 00", o_gnt);
        end
    endtask

    task automatic test_collision();
        logic [7:0] c0;
        capture(16'h00C8, 16'hFEAC);
        c0 = o_frame_count;
        push(2'b01, 16'h00C8, 16'hFEAC);
        d0 = 16'h004B; d1 = 16'h5533; rcv = 1'b1; req = 2'b01;
        cyc(1);
        tests++;
        if (o_gnt !== 2'b01 || o_fresh[0] !== 1'b1 || o_frame_count !== c0 + 8'd1) begin
            fails++;
            $display("FAIL collision: got gnt=%b fresh=%b count=%0d, required 01 fresh[0]=1 count=%0d",
                     o_gnt, o_fresh, o_frame_count, c0 + 8'd1);
        end
        rcv = 1'b0; req = 2'b00;
        cyc(1);
        push(2'b01, 16'h004B, 16'h5533);
        grant0();
        tests++;
        if (o_fresh !== 2'b10) begin
            fails++;
            $display("FAIL collision_fresh: got %b, required 10", o_fresh);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] c0;
        capture(16'h1111, 16'h2222);
        cyc(TO - 2);
        tests++;
        if (o_stale !== 1'b0) begin
            fails++; $display("FAIL stale_early: got %b at %0d cycles, required 0", o_stale, TO - 1);
        end
        cyc(1);
        tests++;
        if (o_stale !== 1'b1) begin
            fails++; $display("FAIL stale_rise: got %b at %0d cycles, required 1", o_stale, TO);
        end
        cyc(5);
        tests++;
        if (o_stale !== 1'b1) begin
            fails++; $display("FAIL stale_hold: got %b, required 1", o_stale);
        end
        rcv = 1'b1;
        cyc(1);
        tests++;
        if (o_stale !== 1'b0) begin
            fails++; $display("FAIL stale_clear: got %b, required 0", o_stale);
        end
        rcv = 1'b0;
        cyc(1);
        // Capture lands on the very edge the counter would saturate.
        cyc(TO - 2);
        rcv = 1'b1;
        cyc(1);
        tests++;
        if (o_stale !== 1'b0) begin
            fails++; $display("FAIL stale_same_cycle: got %b, required 0", o_stale);
        end
        rcv = 1'b0;
        cyc(1);
        c0 = o_frame_count;
        rcv = 1'b1;
        cyc(50);
        rcv = 1'b0;
        cyc(2);
        tests++;
        if (o_frame_count !== c0 + 8'd1) begin
            fails++;
            $display("FAIL level_held: got count=%0d, required %0d", o_frame_count, c0 + 8'd1);
        end
    endtask

    task automatic test_count_wrap();
        do_reset();
        for (int i = 0; i < 255; i++) capture(16'(i), 16'(~i));
        tests++;
        if (o_frame_count !== 8'd255) begin
            fails++; $display("FAIL count_255: got %0d, required 255", o_frame_count);
        end
        capture(16'hAAAA, 16'h5555);
        tests++;
        if (o_frame_count !== 8'd0) begin
            fails++; $display("FAIL count_wrap: got %0d, required 0", o_frame_count);
        end
    endtask

    task automatic test_smooth();
        do_reset();
        capture(16'h0800, 16'h0800);
        push(2'b01, 16'h0800, 16'h0800);
        grant0();
        capture(16'h0000, 16'h0000);
`ifdef ADC_SMOOTH_EN
        push(2'b01, 16'h0700, 16'h0700);
`else
        push(2'b01, 16'h0000, 16'h0000);
`endif
        grant0();
    endtask

    task automatic test_reset_mid_grant();
        capture(16'hABCD, 16'h1234);
        push(2'b01, 16'hABCD, 16'h1234);
        req = 2'b01;
        cyc(1);
        rst_n = 1'b0; req = 2'b00;
        cyc(1);
        tests++;
        if (o_gnt !== 2'b00 || o_fresh !== 2'b00 || o_frame_count !== 8'd0 || o_data0 !== 16'h0) begin
            fails++;
            $display("FAIL reset_mid_grant: got gnt=%b fresh=%b count=%0d data0=%h, required 00 00 0 0000",
                     o_gnt, o_fresh, o_frame_count, o_data0);
        end
        rst_n = 1'b1;
        cyc(2);
    endtask

    initial begin
        test_reset();
        test_capture_grant();
        test_round_robin();
        test_collision();
        test_timeout();
        test_count_wrap();
        test_smooth();
        test_reset_mid_grant();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending grants, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
